// File: rtl/three_deshuffler.sv
// 3-parallel inverse stride shuffler: returns each 3*D-beat block from the
// transposed (delay-commutator) order to lane-major natural order.
module three_deshuffler #(
    parameter int W = 32,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] ao,
    output logic [W-1:0] bo,
    output logic [W-1:0] co,
    output logic         out_valid,
    output logic         out_sof
);

    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = $clog2(2 * D + 1);

    // In-block beat t = g*D + i is tracked as the pair (g, i).
    logic [1:0]    g_q, g_d;
    logic [IW-1:0] i_q, i_d;
    logic          bank_q, bank_d;
    logic [PW-1:0] prime_q, prime_d;
    logic          primed;

    // Ping-pong banks indexed [bank][g][i][input lane].
    logic [W-1:0] mem_q [2][3][D][3];

    logic [W-1:0] ao_q, bo_q, co_q;
    logic         out_valid_q, out_sof_q;

    logic [1:0]   k_rd;
    logic         bank_rd;
    logic [W-1:0] rd0, rd1, rd2;

    assign primed = (prime_q == PW'(2 * D));

    always_comb begin
        g_d     = g_q;
        i_d     = i_q;
        bank_d  = bank_q;
        prime_d = prime_q;
        if (in_valid) begin
            if (i_q == IW'(D - 1)) begin
                i_d = '0;
                if (g_q == 2'd2) begin
                    g_d    = 2'd0;
                    bank_d = ~bank_q;
                end else begin
                    g_d = g_q + 2'd1;
                end
            end else begin
                i_d = i_q + IW'(1);
            end
            if (!primed) begin
                prime_d = prime_q + PW'(1);
            end
        end
    end

    // Output slot is (t + D) mod 3D: same i, source lane k = (g+1) mod 3.
    // During g==2 the slot belongs to the block being written now; its lane-2
    // word is the word arriving on lane a this very beat, so it bypasses.
    always_comb begin
        k_rd    = (g_q == 2'd2) ? 2'd0 : g_q + 2'd1;
        bank_rd = (g_q == 2'd2) ? bank_q : ~bank_q;
        rd0     = mem_q[bank_rd][0][i_q][k_rd];
        rd1     = mem_q[bank_rd][1][i_q][k_rd];
        rd2     = (g_q == 2'd2) ? a : mem_q[bank_rd][2][i_q][k_rd];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g_q         <= '0;
            i_q         <= '0;
            bank_q      <= 1'b0;
            prime_q     <= '0;
            ao_q        <= '0;
            bo_q        <= '0;
            co_q        <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            for (int bk = 0; bk < 2; bk++) begin
                for (int g = 0; g < 3; g++) begin
                    for (int i = 0; i < D; i++) begin
                        for (int k = 0; k < 3; k++) begin
                            mem_q[bk][g][i][k] <= '0;
                        end
                    end
                end
            end
        end else begin
            g_q     <= g_d;
            i_q     <= i_d;
            bank_q  <= bank_d;
            prime_q <= prime_d;
            if (in_valid) begin
                mem_q[bank_q][g_q][i_q][0] <= a;
                mem_q[bank_q][g_q][i_q][1] <= b;
                mem_q[bank_q][g_q][i_q][2] <= c;
                ao_q        <= rd0;
                bo_q        <= rd1;
                co_q        <= rd2;
                out_valid_q <= primed;
                out_sof_q   <= primed && (g_q == 2'd2) && (i_q == '0);
            end else begin
                out_valid_q <= 1'b0;
                out_sof_q   <= 1'b0;
            end
        end
    end

    assign ao        = ao_q;
    assign bo        = bo_q;
    assign co        = co_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;

endmodule

// File: tb/tb_three_deshuffler.sv
// Directed + random bench for three_deshuffler (D=4 and D=1 instances)
// with a spec-formula model feeding an expected-output queue.
module tb_three_deshuffler;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         iv4 = 1'b0, iv1 = 1'b0;
    logic [W-1:0] a = '0, b = '0, c = '0;
    logic [W-1:0] ao4, bo4, co4, ao1, bo1, co1;
    logic         ov4, sof4, ov1, sof1;

    logic [3*W:0]   exp_q[$];
    logic [3*W-1:0] hist[$];
    logic [3*W-1:0] last_data;
    logic           hold_ok;
    int             idx;
    int             total = 0;
    int             bad = 0;

    three_deshuffler #(.W(W), .D(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .a(a), .b(b), .c(c),
        .ao(ao4), .bo(bo4), .co(co4), .out_valid(ov4), .out_sof(sof4)
    );

    three_deshuffler #(.W(W), .D(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a), .b(b), .c(c),
        .ao(ao1), .bo(bo1), .co(co1), .out_valid(ov1), .out_sof(sof1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] lane_of(input logic [3*W-1:0] e, input int k);
        return e[(2-k)*W +: W];
    endfunction

    task automatic do_reset();
        logic [4*W+1:0] obs;
        rst_n = 1'b0;
        iv4 = 1'b0;
        iv1 = 1'b0;
        @(posedge clk);
        #1;
        obs = {ov4, sof4, ao4, bo4, co4};
        total++;
        assert (obs === '0) else begin
            bad++;
            $error("FAIL reset_d4 got=%h want=0", obs);
        end
        obs = {ov1, sof1, ao1, bo1, co1};
        total++;
        assert (obs === '0) else begin
            bad++;
            $error("FAIL reset_d1 got=%h want=0", obs);
        end
        rst_n = 1'b1;
        hist.delete();
        exp_q.delete();
        idx = 0;
        hold_ok = 1'b0;
        last_data = '0;
    endtask

    // Drive one cycle on the selected instance and check what it presents after the edge.
    task automatic step(input int dd, input logic v, input logic [W-1:0] x, y, z);
        logic [3*W:0] e;
        logic [3*W:0] obs;
        logic         ov;
        logic         expect_out;
        int r, n, s, k, i;
        a = x;
        b = y;
        c = z;
        if (dd == 4) iv4 = v; else iv1 = v;
        expect_out = 1'b0;
        if (v) begin
            hist.push_back({x, y, z});
            if (idx >= 2 * dd) begin
                r = idx - 2 * dd;
                n = r / (3 * dd);
                s = r % (3 * dd);
                k = s / dd;
                i = s % dd;
                e = {(s == 0),
                     lane_of(hist[n*3*dd + i], k),
                     lane_of(hist[n*3*dd + dd + i], k),
                     lane_of(hist[n*3*dd + 2*dd + i], k)};
                exp_q.push_back(e);
                expect_out = 1'b1;
            end
            idx++;
        end
        @(posedge clk);
        #1;
        iv4 = 1'b0;
        iv1 = 1'b0;
        ov  = (dd == 4) ? ov4 : ov1;
        obs = (dd == 4) ? {sof4, ao4, bo4, co4} : {sof1, ao1, bo1, co1};
        total++;
        assert (ov === expect_out) else begin
            bad++;
            $error("FAIL out_valid d=%0d idx=%0d got=%b want=%b", dd, idx, ov, expect_out);
        end
        if (expect_out) begin
            e = exp_q.pop_front();
            total++;
            assert (obs === e) else begin
                bad++;
                $error("FAIL data d=%0d idx=%0d got=%h want=%h", dd, idx, obs, e);
            end
            last_data = e[3*W-1:0];
            hold_ok = 1'b1;
        end else if (!v && hold_ok) begin
            total++;
            assert (obs === {1'b0, last_data}) else begin
                bad++;
                $error("FAIL stall_hold d=%0d idx=%0d got=%h want=%h", dd, idx, obs, {1'b0, last_data});
            end
        end
    endtask

    task automatic ramp(input int dd, input int beats, input logic stall3);
        int t;
        t = 0;
        for (int j = 0; t < beats; j++) begin
            if (stall3 && (j % 3 == 2)) begin
                step(dd, 1'b0, $urandom, $urandom, $urandom);
            end else begin
                step(dd, 1'b1, W'(t), W'(100 + t), W'(200 + t));
                t++;
            end
        end
    endtask

    initial begin
        idx = 0;
        hold_ok = 1'b0;
        last_data = '0;
        do_reset();

        // Test 1: one block plus drain, first output after global beat 8.
        ramp(4, 24, 1'b0);

        // Test 2: three back-to-back blocks plus 8 drain beats.
        do_reset();
        ramp(4, 44, 1'b0);

        // Test 3: same ramp with every third cycle stalled.
        do_reset();
        ramp(4, 24, 1'b1);

        // Test 4: reset mid block 1, then restart the ramp.
        do_reset();
        ramp(4, 17, 1'b0);
        do_reset();
        ramp(4, 24, 1'b0);

        // Test 5: D=1 pure 3x3 transpose.
        do_reset();
        step(1, 1'b1, 32'd1, 32'd2, 32'd3);
        step(1, 1'b1, 32'd4, 32'd5, 32'd6);
        step(1, 1'b1, 32'd7, 32'd8, 32'd9);
        step(1, 1'b1, 32'd0, 32'd0, 32'd0);
        step(1, 1'b1, 32'd0, 32'd0, 32'd0);

        // Test 6: random data with random gaps, long runs on both instances.
        do_reset();
        for (int j = 0; j < 200 * 12 + 8; j++) begin
            if ($urandom_range(0, 3) == 0) step(4, 1'b0, $urandom, $urandom, $urandom);
            step(4, 1'b1, $urandom, $urandom, $urandom);
        end
        do_reset();
        for (int j = 0; j < 100 * 3 + 2; j++) begin
            if ($urandom_range(0, 3) == 0) step(1, 1'b0, $urandom, $urandom, $urandom);
            step(1, 1'b1, $urandom, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/three_deshuffler.md
Name: three_deshuffler

Overview:
- 3-parallel inverse data shuffler (stride de-permutation) for the radix-3 parallel FFT datapath.
- Takes three lanes in the shuffled order produced by the 3-parallel delay-commutator shuffler and returns each block to lane-major natural order.
- Sits at the FFT back end, or between stages that need the transposed order undone.
- Self-sequenced: an internal beat counter generates all commutator selects. There are no external select inputs.

Parameters:
- W, 32, lane data width in bits.
- D, 4, stride (sub-block length in beats). Block length is 3*D beats. D >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active low.
- in_valid  input  1  input beat qualifier. Gaps are allowed anywhere.
- a  input  W  lane 0 input.
- b  input  W  lane 1 input.
- c  input  W  lane 2 input.
- ao  output  W  lane 0 output (registered).
- bo  output  W  lane 1 output (registered).
- co  output  W  lane 2 output (registered).
- out_valid  output  1  output beat qualifier.
- out_sof  output  1  high with out_valid on slot 0 of each output block.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All outputs go to 0, including out_valid and out_sof.
  - Beat counter goes to 0. Prime counter goes to 0. All delay/buffer storage is cleared to 0.
  - Reset mid-block discards all partial data. The first in_valid beat after reset is beat 0 of a new block.
- Beat counter:
  - Increments only on in_valid cycles, from 0 to 3D-1, then wraps to 0.
  - In-block index t = g*D + i, with g in {0,1,2} and i in [0,D-1].
- Mapping:
  - The input word on lane k at block beat t = g*D + i appears on output lane g at output-block slot s = k*D + i.
  - Lane 0/1/2 correspond to a/b/c in and ao/bo/co out.
- Timing:
  - The output stream lags the input stream by exactly 2D valid beats.
  - Output slot s of block n is presented the cycle after the input beat with global valid index n*3D + 2D + s is accepted. That is 1 cycle of register latency.
  - On cycles with in_valid=0, internal state holds, ao/bo/co hold their last value, and out_valid=0.
- Prime logic:
  - The prime counter saturates at 2D and counts valid beats since reset.
  - out_valid = registered (in_valid AND prime count == 2D, evaluated before that beat's increment).
  - The first 2D valid beats after reset therefore produce out_valid=0.
- out_sof: registered (in_valid AND primed AND current output slot == 0).
- Stream end: there is no flush port. Upstream pushes 2D trailing beats (any data) to drain the last block. Data in those beats fills the next block.
- Back-to-back blocks with no gaps sustain one output beat per cycle with no bubbles.
- Storage:
  - Implementation choice (delay lines plus commutator, or ping-pong banks).
  - Must be bit-exact to the mapping above for every D >= 1.
  - Data passes through unmodified. No arithmetic.
- D=1 degenerates to a pure 3x3 block transpose with 2 valid beats of lag.

Test Plan:
1. D=4. After reset, drive continuous in_valid with lane k at global beat t = 100*k + t.
   - First out_valid occurs the cycle after global beat 8.
   - Slots 0..3: ao = 0,1,2,3; bo = 4,5,6,7; co = 8,9,10,11.
   - Slots 4..7: ao = 100..103; bo = 104..107.
   - Slots 8..11: co = 208..211.
   - out_sof is high on slot 0 only.
2. Same stimulus for 3 blocks plus 8 drain beats.
   - Blocks 1 and 2 follow block 0 with no bubble.
   - Block 1 slot 0 ao = 12.
3. Same data as test 1, with in_valid deasserted every third cycle.
   - Output values and order are identical to test 1.
   - out_valid=0 and outputs hold on stalled cycles.
4. Assert rst_n=0 for one cycle at global beat 17, mid block 1.
   - Outputs and out_valid go to 0 the next cycle.
   - Restarting stimulus at 0 reproduces test 1 exactly.
5. D=1: inputs beat0 (1,2,3), beat1 (4,5,6), beat2 (7,8,9), then 2 drain beats.
   - Output slots: (1,4,7), (2,5,8), (3,6,9).
6. Loopback with the forward 3-parallel shuffler feeding this block, random 32-bit data, 1000 blocks.
   - Output equals the original input in lane-major order.
   - Block start is recovered via out_sof.
